ysyx_040066_mul_issue: RTL and testbench

//  Issue/collect controller for the 2-stage Booth/Wallace multiplier in the EX stage.
//  - Accepts one RV64M multiply op per valid/ready handshake.
//  - Steps the multiplier pipeline through its two registered stages.
//  - Captures the 64-bit result and returns it to writeback with valid/ready and a tag.
//  - Single outstanding op; supports a pipeline flush.

---
 rtl/ysyx_040066_mul_issue.sv | 129 ++++++++++++
 tb/tb_ysyx_040066_mul_issue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040066_mul_issue.sv
// Issue/collect controller for the two-stage Booth/Wallace multiplier: one op in flight,
// valid/ready on both sides, flushable. Optional build macro: YSYX_040066_MUL_ZERO_SKIP_EN.
module ysyx_040066_mul_issue #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_is_w,
    input  logic [63:0]      in_src1,
    input  logic [63:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [63:0]      mul_src1,
    output logic [63:0]      mul_src2,
    output logic [1:0]       mul_ctr_in,
    output logic [1:0]       mul_ctr,
    output logic             mul_is_w,
    output logic             mul_block,
    input  logic [63:0]      mul_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ST1  = 2'd1,
        ST2  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic             is_w_q;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             skip;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready & ~flush;

    // Operands only matter on the accept edge, so they are passed straight through.
    assign mul_src1 = in_src1;
    assign mul_src2 = in_src2;

`ifdef YSYX_040066_MUL_ZERO_SKIP_EN
    assign skip = accept & ((in_src1 == 64'd0) | (in_src2 == 64'd0));
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_nxt  = state;
        mul_block  = 1'b1;
        mul_ctr_in = op_q;
        mul_ctr    = op_q;
        mul_is_w   = is_w_q;
        case (state)
            IDLE: begin
                // The multiplier sign-extends with mul_ctr on the capture edge, so it must be live.
                mul_ctr_in = in_op;
                mul_ctr    = in_op;
                mul_is_w   = in_is_w;
                mul_block  = ~(accept & ~skip);
                if (accept) state_nxt = skip ? DONE : ST1;
            end
            ST1: begin
                mul_block = 1'b0;
                state_nxt = ST2;
            end
            ST2:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            mul_block = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= 2'b00;
            is_w_q <= 1'b0;
            tag_q  <= '0;
        end else if (accept) begin
            op_q   <= in_op;
            is_w_q <= in_is_w;
            tag_q  <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= 64'd0;
            out_tag    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (skip) begin
                    out_result <= 64'd0;
                    out_tag    <= in_tag;
                    out_valid  <= 1'b1;
                end
                ST2: begin
                    out_result <= mul_result;
                    out_tag    <= tag_q;
                    out_valid  <= 1'b1;
                end
                DONE:    if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_040066_mul_issue.sv
// Directed bench for ysyx_040066_mul_issue with a behavioural two-stage multiplier and a
// scoreboard of expected results/tags.
module tb_ysyx_040066_mul_issue;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, in_is_w;
    logic [1:0]       in_op;
    logic [63:0]      in_src1, in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready;
    logic [63:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [63:0]      mul_src1, mul_src2, mul_result;
    logic [1:0]       mul_ctr_in, mul_ctr;
    logic             mul_is_w, mul_block;

    typedef struct packed {
        logic [63:0]      result;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_040066_mul_issue #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_is_w(in_is_w),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_ctr_in(mul_ctr_in), .mul_ctr(mul_ctr),
        .mul_is_w(mul_is_w), .mul_block(mul_block), .mul_result(mul_result)
    );

    // Behavioural multiplier: stage 1 latches operands, stage 2 latches the selected half.
    function automatic logic [127:0] mul_prod(input logic [1:0] ctr, input logic [63:0] a,
                                              input logic [63:0] b);
        logic [127:0] sa, sb;
        sa = (ctr == 2'b01 || ctr == 2'b10) ? {{64{a[63]}}, a} : {64'd0, a};
        sb = (ctr == 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
        return sa * sb;
    endfunction

    function automatic logic [63:0] mul_sel(input logic [127:0] p, input logic [1:0] ctr,
                                            input logic is_w);
        if (ctr != 2'b00) return p[127:64];
        if (is_w)         return {{32{p[31]}}, p[31:0]};
        return p[63:0];
    endfunction

    logic [63:0] s1_a = 64'd0, s1_b = 64'd0, s2_res = 64'd0;
    logic [1:0]  s1_ctr = 2'b00;
    assign mul_result = s2_res;

    always @(posedge clk) begin
        if (!mul_block) begin
            s1_a   <= mul_src1;
            s1_b   <= mul_src2;
            s1_ctr <= mul_ctr_in;
            s2_res <= mul_sel(mul_prod(s1_ctr, s1_a, s1_b), mul_ctr, mul_is_w);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accept edge (state ST1 or DONE).
    task automatic issue(input logic [1:0] op, input logic is_w, input logic [63:0] a,
                         input logic [63:0] b, input logic [TAG_W-1:0] tag, input bit push,
                         input logic [63:0] exp);
        int   w = 0;
        exp_t e;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("issue_in_ready", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_is_w = is_w;
        in_src1 = a; in_src2 = b; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            e.result = exp;
            e.tag    = tag;
            sb_q.push_back(e);
        end
    endtask

    // Latency counts posedges from the accept edge (inclusive) to out_valid.
    task automatic collect(input string name, input int exp_lat, input int hold);
        int   k = 1;
        exp_t e = '0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, "_latency"}, 64'(k), 64'(exp_lat));
        check({name, "_sb_size"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({name, "_result"}, out_result, e.result);
            check({name, "_tag"}, 64'(out_tag), 64'(e.tag));
        end
        repeat (hold) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, out_valid, 1);
            check({name, "_hold_result"}, out_result, e.result);
            check({name, "_hold_tag"}, 64'(out_tag), 64'(e.tag));
            check({name, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({name, "_drain_valid"}, out_valid, 0);
        check({name, "_drain_in_ready"}, in_ready, 1);
    endtask

    // Flush after 'steps' cycles in flight: 1 = ST1, 2 = ST2, 3 = DONE.
    task automatic flush_test(input string name, input int steps);
        issue(2'b00, 1'b0, 64'd5, 64'd6, 5'd17, 1'b0, 64'd0);
        repeat (steps - 1) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check({name, "_valid"}, out_valid, 0);
        check({name, "_in_ready"}, in_ready, 1);
        repeat (4) begin
            @(posedge clk); #1;
            check({name, "_quiet"}, out_valid, 0);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_is_w = 1'b0; in_op = 2'b00;
        in_src1 = 64'd0; in_src2 = 64'd0; in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_mul_block", mul_block, 1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        issue(2'b00, 1'b0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        collect("mul_7x_m3", 3, 0);

        issue(2'b11, 1'b0, '1, '1, 5'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        collect("mulhu", 3, 0);
        issue(2'b01, 1'b0, '1, '1, 5'd2, 1'b1, 64'd0);
        collect("mulh", 3, 0);
        issue(2'b10, 1'b0, '1, 64'd2, 5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        collect("mulhsu", 3, 0);

        out_ready = 1'b0;
        issue(2'b00, 1'b1, 64'h8000_0000, 64'd1, 5'd30, 1'b1, 64'hFFFF_FFFF_8000_0000);
        collect("mulw_hold", 3, 5);

        flush_test("flush_st1", 1);
        flush_test("flush_st2", 2);
        out_ready = 1'b0;
        flush_test("flush_done", 3);
        issue(2'b00, 1'b0, 64'd3, 64'd4, 5'd8, 1'b1, 64'd12);
        collect("mul_after_flush", 3, 0);

        in_valid = 1'b1; in_op = 2'b00; in_src1 = 64'd9; in_src2 = 64'd9; flush = 1'b1;
        #1;
        check("idle_flush_mul_block", mul_block, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush_in_ready", in_ready, 1);
        check("idle_flush_valid", out_valid, 0);

        issue(2'b00, 1'b0, 64'd11, 64'd13, 5'd21, 1'b0, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_st2_out_valid", out_valid, 0);
        check("rst_st2_mul_block", mul_block, 1);
        check("rst_st2_in_ready", in_ready, 1);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        issue(2'b00, 1'b0, 64'd3, 64'd4, 5'd9, 1'b1, 64'd12);
        collect("mul_after_rst", 3, 0);

`ifdef YSYX_040066_MUL_ZERO_SKIP_EN
        issue(2'b00, 1'b0, 64'd0, 64'h1234, 5'd14, 1'b1, 64'd0);
        collect("zero_op", 1, 0);
`else
        issue(2'b00, 1'b0, 64'd0, 64'h1234, 5'd14, 1'b1, 64'd0);
        collect("zero_op", 3, 0);
`endif

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
